// File: rtl/dm_arbiter_pkg.sv
// Shared types for the dm access path: access-type codes, controller states,
// and the address legality helpers used at grant time.
// No logic or ports; imported by the arbiter and the bench.
package dm_pkg;

   typedef enum logic [2:0] {
      DM_WORD  = 3'b000,
      DM_HALF  = 3'b001,
      DM_HALFU = 3'b010,
      DM_BYTE  = 3'b011,
      DM_BYTEU = 3'b100
   } dm_type_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_CAPTURE,
      ST_RESP
   } dm_state_e;

   // Natural alignment by access size; undefined codes are never aligned,
   // which makes them an error for loads as well as stores.
   function automatic logic is_aligned(input logic [2:0] t, input logic [1:0] a);
      case (t)
         DM_WORD:            return a == 2'b00;
         DM_HALF, DM_HALFU:  return ~a[0];
         DM_BYTE, DM_BYTEU:  return 1'b1;
         default:            return 1'b0;
      endcase
   endfunction

   // Unsigned variants only make sense when extending load data.
   function automatic logic store_type_ok(input logic [2:0] t);
      return (t == DM_WORD) || (t == DM_HALF) || (t == DM_BYTE);
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the two-requester request bus, the response channel and the
// registered dm drive/return signals.
// slave: arbiter side; master: requesters, response sink and dm side.
interface dm_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_wr;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [5:0]          req_type;

   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_id;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;

   logic                mem_wr;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_din;
   logic [2:0]          mem_type;
   logic [DATA_W-1:0]   mem_dout;

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_type, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
      output mem_wr, mem_addr, mem_din, mem_type
   );

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_type, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
      input  mem_wr, mem_addr, mem_din, mem_type
   );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester not granted last.
// Latency: combinational grant; last_grant updates on the granting edge.
// Backpressure: grants only while en is high; ports clk, rstn, en, req -> gnt, gnt_id.
module rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);
   logic last_q, last_d;
   logic id_c;
   logic fire_c;

   always_comb begin
      id_c   = req[1];
      fire_c = en && (req != 2'b00);
      if (req == 2'b11) begin
         id_c = ~last_q;
      end
      last_d = fire_c ? id_c : last_q;
   end

   assign gnt    = fire_c ? (id_c ? 2'b10 : 2'b01) : 2'b00;
   assign gnt_id = id_c;

   // Resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
endmodule

// File: rtl/dm_arbiter.sv
// Round-robin access controller for dm: grant, alignment check, one access, response.
// Latency: rsp_valid 3 cycles after grant for a legal access, 1 cycle for an error.
// Backpressure: one access in flight; response held until rsp_ready, no grant meanwhile.
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rstn,
   dm_arbiter_if.slave   bus
);
   dm_state_e state_q, state_d;

   logic              mem_wr_q,   mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q,  mem_din_d;
   logic [2:0]        mem_type_q, mem_type_d;
   logic              store_q,    store_d;
   logic              rsp_id_q,   rsp_id_d;
   logic              rsp_err_q,  rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [1:0]        gnt;
   logic              gnt_id;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        sel_type;
   logic              sel_ok;

   rr_arb2 u_arb (
      .clk    (clk),
      .rstn   (rstn),
      .en     (state_q == ST_IDLE),
      .req    (bus.req_valid),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Request fields of whichever requester the arbiter is pointing at.
   assign sel_wr    = bus.req_wr[gnt_id];
   assign sel_addr  = gnt_id ? bus.req_addr[2*ADDR_W-1:ADDR_W]   : bus.req_addr[ADDR_W-1:0];
   assign sel_wdata = gnt_id ? bus.req_wdata[2*DATA_W-1:DATA_W]  : bus.req_wdata[DATA_W-1:0];
   assign sel_type  = gnt_id ? bus.req_type[5:3]                 : bus.req_type[2:0];
   assign sel_ok    = is_aligned(sel_type, sel_addr[1:0]) && (!sel_wr || store_type_ok(sel_type));

   always_comb begin
      state_d     = state_q;
      mem_wr_d    = 1'b0;        // write strobe lives for the ACCESS cycle only
      mem_addr_d  = mem_addr_q;  // address/type held so CAPTURE re-reads the same location
      mem_din_d   = mem_din_q;
      mem_type_d  = mem_type_q;
      store_d     = store_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               rsp_id_d = gnt_id;
               store_d  = sel_wr;
               if (sel_ok) begin
                  mem_wr_d   = sel_wr;
                  mem_addr_d = sel_addr;
                  mem_din_d  = sel_wdata;
                  mem_type_d = sel_type;
                  rsp_err_d  = 1'b0;
                  state_d    = ST_ACCESS;
               end else begin
                  // Illegal requests never touch the memory.
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_ACCESS:  state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            // dm registers its read data, so it is valid during this cycle.
            rsp_rdata_d = store_q ? '0 : bus.mem_dout;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_type_q  <= DM_WORD;
         store_q     <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_type_q  <= mem_type_d;
         store_q     <= store_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_type  = mem_type_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural dm memory, directed scenarios, then
// randomized traffic checked against a byte-array reference model.
module tb_dm_arbiter;
   import dm_pkg::*;

   logic clk;
   logic rstn;

   dm_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   dm_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passes = 0;
   int fails  = 0;
   int total  = 0;
   int wr_cnt = 0;

   logic [7:0]  dm_mem  [64];
   logic [7:0]  ref_mem [64];

   // Requester-side copies of the presented requests, and the model's grant pointer.
   bit          pv    [2];
   logic        p_wr  [2];
   int          p_addr[2];
   int          p_typ [2];
   logic [31:0] p_wd  [2];
   bit          last_g;

   // ---------------- dm behavioural memory (registered read) ----------------
   function automatic logic [31:0] dm_read(input logic [5:0] a, input logic [2:0] t);
      logic [7:0] b0, b1, b2, b3;
      b0 = dm_mem[a];
      b1 = dm_mem[a + 6'd1];
      b2 = dm_mem[a + 6'd2];
      b3 = dm_mem[a + 6'd3];
      case (t)
         3'd0:    return {b3, b2, b1, b0};
         3'd1:    return {{16{b1[7]}}, b1, b0};
         3'd2:    return {16'd0, b1, b0};
         3'd3:    return {{24{b0[7]}}, b0};
         3'd4:    return {24'd0, b0};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.mem_wr === 1'b1) begin
         wr_cnt++;
         dm_mem[bus.mem_addr] = bus.mem_din[7:0];
         if (bus.mem_type != 3'd3) dm_mem[bus.mem_addr + 6'd1] = bus.mem_din[15:8];
         if (bus.mem_type == 3'd0) begin
            dm_mem[bus.mem_addr + 6'd2] = bus.mem_din[23:16];
            dm_mem[bus.mem_addr + 6'd3] = bus.mem_din[31:24];
         end
      end else begin
         bus.mem_dout <= dm_read(bus.mem_addr, bus.mem_type);
      end
   end

   // ---------------- reference model ----------------
   // Size/sign from the type code, error rules from plain arithmetic, store side effect on ref_mem.
   function automatic void predict(input logic wr, input int addr, input int typ,
                                   input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int sz;
      bit sgn;
      case (typ)
         0:       sz = 4;
         1, 2:    sz = 2;
         3, 4:    sz = 1;
         default: sz = 0;
      endcase
      sgn = (typ == 1) || (typ == 3);
      err = (sz == 0) || (wr && (typ == 2 || typ == 4));
      if (!err) err = (addr % sz) != 0;
      rd = 32'd0;
      if (!err) begin
         for (int k = 0; k < sz; k++) begin
            if (wr) ref_mem[(addr + k) % 64] = wd[8*k +: 8];
            else    rd = rd | (32'(ref_mem[(addr + k) % 64]) << (8*k));
         end
         if (!wr && sgn && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8*sz));
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic present(input int i, input logic wr, input int addr, input int typ,
                          input logic [31:0] wd);
      p_wr[i] = wr; p_addr[i] = addr; p_typ[i] = typ; p_wd[i] = wd; pv[i] = 1'b1;
      bus.req_wr[i]             = wr;
      bus.req_addr[i*6 +: 6]    = 6'(addr);
      bus.req_type[i*3 +: 3]    = 3'(typ);
      bus.req_wdata[i*32 +: 32] = wd;
      bus.req_valid[i]          = 1'b1;
   endtask

   task automatic present_rand(input int i);
      int a;
      int t;
      a = $urandom_range(15) * 4;
      if ($urandom_range(3) == 0) a = a + $urandom_range(3);
      t = ($urandom_range(7) == 0) ? $urandom_range(7, 5) : $urandom_range(4);
      present(i, 1'($urandom_range(1)), a, t, $urandom);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({pfx, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
      chk({pfx, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
      chk({pfx, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      chk({pfx, "_mem_wr"},    32'(bus.mem_wr),    32'd0);
      chk({pfx, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({pfx, "_mem_din"},   bus.mem_din,        32'd0);
      chk({pfx, "_mem_type"},  32'(bus.mem_type),  32'(DM_WORD));
   endtask

   // Called #1 after an edge while the DUT is idle and requests are presented.
   // hold: cycles to keep rsp_ready low; early: raise rsp_ready before the response.
   task automatic serve(input int hold, input bit early);
      int g, lat, wc0;
      logic err, wr;
      logic [31:0] rd;
      #1;
      if (pv[0] && pv[1]) g = last_g ? 0 : 1;
      else                g = pv[1] ? 1 : 0;
      chk("grant", 32'(bus.req_ready), 32'(1 << g));
      wr = p_wr[g];
      predict(p_wr[g], p_addr[g], p_typ[g], p_wd[g], err, rd);
      last_g = g[0];
      wc0 = wr_cnt;
      @(posedge clk); #1;
      bus.req_valid[g] = 1'b0;
      pv[g] = 1'b0;
      if (early) bus.rsp_ready = 1'b1;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         chk("busy_no_grant", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency",    32'(lat),           err ? 32'd1 : 32'd3);
      chk("rsp_id",     32'(bus.rsp_id),    32'(g));
      chk("rsp_err",    32'(bus.rsp_err),   32'(err));
      chk("rsp_rdata",  bus.rsp_rdata,      rd);
      chk("mem_writes", 32'(wr_cnt - wc0),  (wr && !err) ? 32'd1 : 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_rdata", bus.rsp_rdata,      rd);
         chk("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("rsp_done", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc0;
      for (int i = 0; i < 64; i++) begin
         dm_mem[i]  = 8'(i * 37 + 11);
         ref_mem[i] = 8'(i * 37 + 11);
      end
      pv[0] = 1'b0; pv[1] = 1'b0; last_g = 1'b1;
      rstn = 1'b0;
      bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
      bus.req_wdata = '0; bus.req_type = '0; bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      // Contention from reset: 0, 1, 0, then the still-pending 1
      present(0, 1'b0, 8, 0, 32'd0);
      present(1, 1'b0, 12, 0, 32'd0);
      serve(0, 1'b0);
      present(0, 1'b0, 16, 0, 32'd0);
      serve(0, 1'b0);
      present(1, 1'b0, 20, 0, 32'd0);
      serve(0, 1'b0);
      serve(0, 1'b0);

      // Word store then load
      present(0, 1'b1, 4, 0, 32'hDEAD_BEEF); serve(0, 1'b0);
      present(0, 1'b0, 4, 0, 32'd0);         serve(0, 1'b0);

      // Sign / zero extension
      present(0, 1'b1, 1, 3, 32'h0000_0080); serve(0, 1'b0);
      present(0, 1'b0, 1, 3, 32'd0);         serve(0, 1'b0);
      present(0, 1'b0, 1, 4, 32'd0);         serve(0, 1'b0);
      present(0, 1'b1, 2, 1, 32'h0000_8001); serve(0, 1'b0);
      present(0, 1'b0, 2, 2, 32'd0);         serve(0, 1'b0);
      present(1, 1'b0, 2, 1, 32'd0);         serve(0, 1'b0);
      present(1, 1'b0, 60, 0, 32'd0);        serve(0, 1'b0);

      // Errors: misaligned half load, BYTEU store, undefined load code, misaligned word store
      present(0, 1'b0, 3, 1, 32'd0);         serve(0, 1'b0);
      present(1, 1'b1, 5, 4, 32'h1234_5678); serve(0, 1'b0);
      present(0, 1'b0, 8, 6, 32'd0);         serve(0, 1'b0);
      present(1, 1'b1, 2, 0, 32'hCAFE_F00D); serve(0, 1'b0);

      // Backpressure: response held 5 cycles, other requester pending, granted right after
      present(0, 1'b0, 4, 0, 32'd0);
      present(1, 1'b0, 8, 0, 32'd0);
      serve(5, 1'b0);
      serve(0, 1'b0);

      // rsp_ready raised before rsp_valid
      present(1, 1'b0, 12, 0, 32'd0);
      serve(0, 1'b1);

      // Reset during the ACCESS cycle of a store
      present(0, 1'b1, 16, 0, 32'h1234_5678);
      #1;
      chk("mid_grant", 32'(bus.req_ready), 32'd1);
      wc0 = wr_cnt;
      @(posedge clk); #1;
      chk("mid_access_wr", 32'(bus.mem_wr), 32'd1);
      rstn = 1'b0;
      bus.req_valid = '0; pv[0] = 1'b0; pv[1] = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_write", 32'(wr_cnt - wc0), 32'd0);
      rstn = 1'b1;
      last_g = 1'b1;
      @(posedge clk); #1;
      present(0, 1'b0, 16, 0, 32'd0);
      serve(0, 1'b0);

      // Randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pv[i] && $urandom_range(3) != 0) present_rand(i);
         end
         if (!pv[0] && !pv[1]) present_rand(0);
         serve($urandom_range(2), 1'($urandom_range(5) == 0));
      end
      while (pv[0] || pv[1]) serve(0, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
